// File: rtl/hazard_pkg.sv
// Shared constants for the load-hazard scoreboard.
//   REG_IDX_W    : width of an architectural register index
//   NREG         : number of architectural registers
//   X0           : index of the hardwired-zero register (never tracked)
//   MAX_PEND_DEF : default number of loads allowed in flight
package hazard_pkg;

   localparam int unsigned REG_IDX_W    = 5;
   localparam int unsigned NREG         = 32;
   localparam logic [REG_IDX_W-1:0] X0  = '0;
   localparam int unsigned MAX_PEND_DEF = 2;

endpackage : hazard_pkg

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count this cycle
//   count    : current value, sticks at all-ones
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next value: hold at all-ones instead of wrapping
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule : sat_counter

// File: rtl/hazard_scoreboard.sv
// Load-hazard scoreboard: tracks destinations of in-flight loads and stalls
// ID when an operand (or a load destination) is still owed by data memory.
//   clk, rst                 : clock, asynchronous active-high reset
//   id_valid/id_rs1/id_rs2   : ID instruction and its source indices
//   id_uses_rs1/id_uses_rs2  : source actually read
//   id_rd/id_is_load         : destination and load flag
//   flush                    : ID instruction killed this cycle
//   wb_load_done/wb_rd       : load write-back this cycle
//   stall                    : combinational ID/IF hold
//   busy_mask/pending_cnt    : registered tracking state
//   stall_cycles             : saturating stalled-cycle count
//   err_underflow            : sticky completion-to-non-busy flag
module hazard_scoreboard #(
   parameter int unsigned NREG     = hazard_pkg::NREG,
   parameter int unsigned MAX_PEND = hazard_pkg::MAX_PEND_DEF,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                id_valid,
   input  logic [hazard_pkg::REG_IDX_W-1:0]    id_rs1,
   input  logic [hazard_pkg::REG_IDX_W-1:0]    id_rs2,
   input  logic                                id_uses_rs1,
   input  logic                                id_uses_rs2,
   input  logic [hazard_pkg::REG_IDX_W-1:0]    id_rd,
   input  logic                                id_is_load,
   input  logic                                flush,
   input  logic                                wb_load_done,
   input  logic [hazard_pkg::REG_IDX_W-1:0]    wb_rd,
   output logic                                stall,
   output logic [NREG-1:0]                     busy_mask,
   output logic [$clog2(MAX_PEND+1)-1:0]       pending_cnt,
   output logic [CNT_W-1:0]                    stall_cycles,
   output logic                                err_underflow
);

   import hazard_pkg::*;

   localparam int unsigned PW = $clog2(MAX_PEND + 1);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] busy_eff;
   logic [PW-1:0]   pend_q;
   logic [PW-1:0]   pend_d;
   logic [PW-1:0]   pend_after;
   logic            err_q;
   logic            err_d;
   logic            rs1_hit;
   logic            rs2_hit;
   logic            rd_hit;
   logic            wb_busy;
   logic            read_haz;
   logic            waw_haz;
   logic            cap_haz;
   logic            clr_vld;
   logic            set_vld;
   logic            issue;

   // Per-register decode; loops start at 1 so x0 never matches anything.
   // A register completing this cycle is forwardable, so lookups use busy_eff.
   always_comb begin
      clr_mask = '0;
      rs1_hit  = 1'b0;
      rs2_hit  = 1'b0;
      rd_hit   = 1'b0;
      wb_busy  = 1'b0;
      for (int unsigned i = 1; i < NREG; i++) begin
         clr_mask[i] = wb_load_done && (wb_rd == REG_IDX_W'(i));
      end
      busy_eff = busy_q & ~clr_mask;
      for (int unsigned i = 1; i < NREG; i++) begin
         rs1_hit = rs1_hit | ((id_rs1 == REG_IDX_W'(i)) && busy_eff[i]);
         rs2_hit = rs2_hit | ((id_rs2 == REG_IDX_W'(i)) && busy_eff[i]);
         rd_hit  = rd_hit  | ((id_rd  == REG_IDX_W'(i)) && busy_eff[i]);
         wb_busy = wb_busy | ((wb_rd  == REG_IDX_W'(i)) && busy_q[i]);
      end
   end

   // Hazard classification and issue decision
   always_comb begin
      clr_vld    = wb_load_done && wb_busy;
      pend_after = pend_q - PW'(clr_vld);
      read_haz   = (id_uses_rs1 && rs1_hit) || (id_uses_rs2 && rs2_hit);
      waw_haz    = id_is_load && rd_hit;
      cap_haz    = id_is_load && (pend_after == PW'(MAX_PEND));
      stall      = !rst && id_valid && !flush && (read_haz || waw_haz || cap_haz);
      issue      = id_valid && !flush && !stall;
      set_vld    = issue && id_is_load && (id_rd != X0);
   end

   // Next tracking state; OR-ing the set after the clear makes set win
   always_comb begin
      set_mask = '0;
      for (int unsigned i = 1; i < NREG; i++) begin
         set_mask[i] = set_vld && (id_rd == REG_IDX_W'(i));
      end
      busy_d = busy_eff | set_mask;
      pend_d = pend_q + PW'(set_vld) - PW'(clr_vld);
      err_d  = err_q | (wb_load_done && (wb_rd != X0) && !wb_busy);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall),
      .count (stall_cycles)
   );

   assign busy_mask     = busy_q;
   assign pending_cnt   = pend_q;
   assign err_underflow = err_q;

endmodule : hazard_scoreboard

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks destination registers of in-flight variable-latency loads in the 5-stage RISC-V pipeline and stalls the ID stage when a source or destination register cannot be covered by EX/MEM or MEM/WB forwarding. It is the producer-side counterpart of the forwarding logic. Forwarding covers single-cycle ALU results. This block holds back any instruction whose operand is still owed by the data memory. It sits between ID (issue side) and WB (retire side) and drives the global ID/IF stall.

## Interface
Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- MAX_PEND, 2, maximum loads outstanding at once (1..NREG-1).
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1, id_rs2  in  5 each  source register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads that source.
- id_rd  in  5  destination index.
- id_is_load  in  1  instruction is a load (long latency).
- flush  in  1  branch/jump redirect; the ID instruction is killed this cycle.
- wb_load_done  in  1  a load's data is written back this cycle.
- wb_rd  in  5  destination of the completing load.
- stall  out  1  combinational; hold PC and IF/ID, bubble ID/EX.
- busy_mask  out  NREG  registered busy bits; bit 0 is always 0.
- pending_cnt  out  $clog2(MAX_PEND+1)  registered outstanding-load count.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.
- err_underflow  out  1  sticky; set when a completion arrives for a non-busy register.

## Operation
- clr_mask = one-hot(wb_rd) when wb_load_done && wb_rd!=0, else 0.
- busy_eff = busy & ~clr_mask. A register completing this cycle is forwardable from MEM/WB next cycle and causes no stall.
- A read hazard exists when (id_uses_rs1 && rs1!=0 && busy_eff[rs1]) or the same condition holds for rs2.
- A WAW hazard exists when id_is_load && rd!=0 && busy_eff[rd].
- A capacity stall exists when id_is_load && (pending_cnt - (wb_load_done && busy[wb_rd] ? 1:0)) == MAX_PEND.
- stall = id_valid && !flush && (read || WAW || capacity). flush overrides stall.
- issue = id_valid && !flush && !stall.
- On issue with id_is_load && id_rd!=0, busy[id_rd] is set.
- A valid completion (wb_load_done && wb_rd!=0 && busy[wb_rd]) clears busy[wb_rd] and decrements pending_cnt.
- A completion to a non-busy register, or with wb_rd==0, changes no state. For the non-busy case it sets err_underflow. err_underflow clears only on rst.
- Set and clear in the same cycle: both apply. Different indices are independent. On the same index, set wins. This case is unreachable through the WAW rule but is defined anyway.
- pending_cnt next = cnt + set - clr; it never wraps.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
- x0 loads (rd=0) issue without tracking and never count toward capacity.

## Timing
- Reset values: busy_mask=0, pending_cnt=0, stall_cycles=0, err_underflow=0. stall is 0 while rst is asserted, regardless of inputs.
- stall has zero-cycle latency (combinational from ID/WB inputs). busy_mask and pending_cnt reflect an issue/completion one cycle later.
- Load-to-use: a consumer issues in the same cycle its producer's wb_load_done is high, never earlier.
- Reset mid-operation clears all tracking immediately. Loads still in flight are the memory's responsibility; their later completions set err_underflow.
- The bench must never assert wb_load_done for an index twice without a re-issue.

## Structure
- Shared package hazard_pkg: REG_IDX_W=5, NREG, X0 constant, and the MAX_PEND default.
- Sub-module sat_counter (parameter W; inc, rst) for stall_cycles.
- Busy vector, hazard compare and count logic stay in the top module.

## Test plan
- Reset then idle: all outputs 0. Load x5 issues → next cycle busy_mask=0x20 and pending_cnt=1.
- With x5 busy, ID add reads rs1=x5 → stall=1 for each cycle until wb_load_done/wb_rd=5, when stall=0 and the add issues. stall_cycles equals the number of stalled cycles.
- With MAX_PEND=2, loads x3 and x4 outstanding, a third load x6 → stall=1. In the cycle x3 completes, stall=0, x6 issues, and pending_cnt stays 2.
- WAW case: x7 busy and a load to x7 in ID → stall=1. The same cycle with flush=1 → stall=0 and no busy bit is set.
- Load rd=0 → busy_mask stays 0 and pending_cnt stays 0. wb_load_done on non-busy x9 → err_underflow=1, held until rst.
- Async rst asserted mid-cycle with 2 pending → busy_mask=0 and pending_cnt=0 immediately, without waiting for clk.
